bit_deserializer: RTL

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/bit_deserializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel frame receiver: start bit, DATA_W data bits LSB first, optional
// even-parity bit (enabled by defining PARITY_CHECK_EN), stop bit; one-word output buffer.
module bit_deserializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              d,
  input  logic              bit_en,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_err,
  output logic              overflow
`ifdef PARITY_CHECK_EN
  ,
  output logic              par_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic               stop_sample;
  logic               frame_good;
  logic               frame_bad;
  logic               load;
  logic               drop;
`ifdef PARITY_CHECK_EN
  logic               pflag, pflag_nxt;
  logic               parity_bad;
`endif

  // Frame sequencing: every state change is gated by the sample strobe
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    stop_sample = 1'b0;
`ifdef PARITY_CHECK_EN
    pflag_nxt   = pflag;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!d) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
`ifdef PARITY_CHECK_EN
            pflag_nxt = 1'b0;
`endif
          end
        end
        DATA: begin
          shreg_nxt = {d, shreg[DATA_W-1:1]};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          // Even parity: the parity bit must equal the XOR of the data bits
          pflag_nxt = d ^ (^shreg);
          state_nxt = STOP;
        end
`endif
        STOP: begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef PARITY_CHECK_EN
      pflag <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
`ifdef PARITY_CHECK_EN
      pflag <= pflag_nxt;
`endif
    end
  end

  // Frame verdict at the stop sample; a bad stop bit masks a parity error
`ifdef PARITY_CHECK_EN
  assign frame_good = stop_sample && d && !pflag;
  assign parity_bad = stop_sample && d && pflag;
`else
  assign frame_good = stop_sample && d;
`endif
  assign frame_bad = stop_sample && !d;
  assign load      = frame_good && (!word_valid || word_ready);
  assign drop      = frame_good && word_valid && !word_ready;

  // Output buffer: a new word may replace one accepted in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err    <= 1'b0;
`endif
    end else begin
      frame_err <= frame_bad;
      overflow  <= drop;
`ifdef PARITY_CHECK_EN
      par_err   <= parity_bad;
`endif
      if (load) begin
        word_out   <= shreg;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
